// File: rtl/snitch_tcdm_bank_responder.sv
// Behavioural single-port TCDM bank: fixed-latency responses,
// byte-strobed writes and a two-cycle atomic read-modify-write.
`timescale 1ns/1ps

package reqrsp_pkg;

    typedef enum logic [3:0] {
        AMONone = 4'h0,
        AMOSwap = 4'h1,
        AMOAdd  = 4'h2,
        AMOAnd  = 4'h3,
        AMOOr   = 4'h4,
        AMOXor  = 4'h5,
        AMOMax  = 4'h6,
        AMOMaxu = 4'h7,
        AMOMin  = 4'h8,
        AMOMinu = 4'h9,
        AMOLR   = 4'hA,
        AMOSC   = 4'hB
    } amo_op_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        user;
        amo_op_e     amo;
    } tcdm_req_chan_t;

    typedef struct packed {
        tcdm_req_chan_t q;
        logic           q_valid;
    } tcdm_req_t;

    typedef struct packed {
        logic [63:0] data;
    } tcdm_rsp_chan_t;

    typedef struct packed {
        tcdm_rsp_chan_t p;
        logic           q_ready;
    } tcdm_rsp_t;

endpackage

module snitch_tcdm_bank_responder
    import reqrsp_pkg::*;
#(
    parameter int unsigned NumWords              = 512,
    parameter int unsigned DataWidth             = 64,
    parameter int unsigned MemAddrWidth          = 32,
    parameter int unsigned MemoryResponseLatency = 1,
    parameter type         mem_req_t             = reqrsp_pkg::tcdm_req_t,
    parameter type         mem_rsp_t             = reqrsp_pkg::tcdm_rsp_t
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  mem_req_t mem_req_i,
    output mem_rsp_t mem_rsp_o,
    input  logic     stall_i
);

    localparam int unsigned AW    = $clog2(NumWords);
    localparam int unsigned LW    = $clog2(DataWidth);
    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned Lat   = MemoryResponseLatency;

    typedef enum logic {
        Idle,
        AmoWrite
    } state_e;

    logic [DataWidth-1:0] r_mem [NumWords];
    logic [DataWidth-1:0] r_pipe [Lat];

    state_e        r_state;
    amo_op_e       r_amo;
    logic [AW-1:0] r_idx;
    logic [LW-1:0] r_lsb;
    logic [31:0]   r_operand;

    logic [MemAddrWidth-1:0] w_addr;
    logic [AW-1:0]           w_idx;
    logic [DataWidth-1:0]    w_wdata;
    logic [StrbW-1:0]        w_strb;
    logic [DataWidth-1:0]    w_rdata;
    logic [DataWidth-1:0]    w_resp;
    logic [DataWidth-1:0]    w_cur;
    logic [31:0]             w_old;
    logic [31:0]             w_res;
    logic [LW-1:0]           w_lsb;
    logic                    w_hi;
    logic                    w_ready;
    logic                    w_acc;
    logic                    w_is_amo;
    logic                    w_is_sc;
    logic                    w_do_write;
    logic                    w_unused;

    assign w_addr  = mem_req_i.q.addr;
    assign w_idx   = w_addr[AW-1:0];
    assign w_wdata = mem_req_i.q.data;
    assign w_strb  = mem_req_i.q.strb;
    assign w_rdata = r_mem[w_idx];

    assign w_ready = !stall_i && (r_state == Idle);
    assign w_acc   = mem_req_i.q_valid && w_ready;

    assign w_is_amo = (mem_req_i.q.amo >= AMOSwap)
                   && (mem_req_i.q.amo <= AMOMinu);
    assign w_is_sc  = (mem_req_i.q.amo == AMOSC);
    assign w_do_write = !w_is_amo && (mem_req_i.q.write || w_is_sc);

    // Atomics target the upper 32-bit lane when any upper strobe is set
    if (DataWidth == 64) begin : g_lane64
        assign w_hi = |w_strb[7:4];
    end else begin : g_lane32
        assign w_hi = 1'b0;
    end

    assign w_lsb  = LW'(w_hi) << 5;
    assign w_resp = w_is_sc ? '0 : w_rdata;

    assign w_cur = r_mem[r_idx];
    assign w_old = w_cur[r_lsb +: 32];

    always_comb begin
        w_res = w_old;
        unique case (r_amo)
            AMOSwap: w_res = r_operand;
            AMOAdd:  w_res = w_old + r_operand;
            AMOAnd:  w_res = w_old & r_operand;
            AMOOr:   w_res = w_old | r_operand;
            AMOXor:  w_res = w_old ^ r_operand;
            AMOMax:  w_res = ($signed(w_old) > $signed(r_operand))
                             ? w_old : r_operand;
            AMOMaxu: w_res = (w_old > r_operand) ? w_old : r_operand;
            AMOMin:  w_res = ($signed(w_old) < $signed(r_operand))
                             ? w_old : r_operand;
            AMOMinu: w_res = (w_old < r_operand) ? w_old : r_operand;
            default: w_res = w_old;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= Idle;
            r_amo     <= AMONone;
            r_idx     <= '0;
            r_lsb     <= '0;
            r_operand <= '0;
        end else begin
            unique case (r_state)
                Idle: begin
                    if (w_acc && w_is_amo) begin
                        r_state   <= AmoWrite;
                        r_amo     <= mem_req_i.q.amo;
                        r_idx     <= w_idx;
                        r_lsb     <= w_lsb;
                        r_operand <= w_wdata[w_lsb +: 32];
                    end
                end
                AmoWrite: r_state <= Idle;
                default:  r_state <= Idle;
            endcase
        end
    end

    // Storage is deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (w_acc && w_do_write) begin
            for (int b = 0; b < StrbW; b++) begin
                if (w_strb[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end else if (r_state == AmoWrite) begin
            r_mem[r_idx][r_lsb +: 32] <= w_res;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Lat; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            if (w_acc) begin
                r_pipe[0] <= w_resp;
            end
            for (int i = 1; i < Lat; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    always_comb begin
        mem_rsp_o         = '0;
        mem_rsp_o.q_ready = w_ready;
        mem_rsp_o.p.data  = r_pipe[Lat-1];
    end

    assign w_unused = ^{w_addr, mem_req_i.q.user};

endmodule

// File: tb/tb_snitch_tcdm_bank_responder.sv
// Directed vector bench for the TCDM bank responder at
// latency 1 and latency 3.
`timescale 1ns/1ps

module tb_snitch_tcdm_bank_responder;
    import reqrsp_pkg::*;

    typedef struct {
        logic        wr;
        amo_op_e     amo;
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  strb;
        logic        chk;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        int          due;
        logic [63:0] val;
    } pend_t;

    logic      clk;
    logic      rst_n;
    logic      stall1;
    logic      stall3;
    tcdm_req_t req1;
    tcdm_req_t req3;
    tcdm_rsp_t rsp1;
    tcdm_rsp_t rsp3;

    int checks;
    int errors;

    vec_t  vecs[$];
    pend_t pend[$];

    snitch_tcdm_bank_responder #(
        .NumWords(512),
        .DataWidth(64),
        .MemAddrWidth(32),
        .MemoryResponseLatency(1)
    ) u_dut1 (
        .clk_i(clk),
        .rst_ni(rst_n),
        .mem_req_i(req1),
        .mem_rsp_o(rsp1),
        .stall_i(stall1)
    );

    snitch_tcdm_bank_responder #(
        .NumWords(512),
        .DataWidth(64),
        .MemAddrWidth(32),
        .MemoryResponseLatency(3)
    ) u_dut3 (
        .clk_i(clk),
        .rst_ni(rst_n),
        .mem_req_i(req3),
        .mem_rsp_o(rsp3),
        .stall_i(stall3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input amo_op_e amo,
                                input logic [31:0] addr,
                                input logic [63:0] data,
                                input logic [7:0] strb,
                                input logic c, input logic [63:0] exp);
        vec_t v;
        v.wr = wr; v.amo = amo; v.addr = addr; v.data = data;
        v.strb = strb; v.chk = c; v.exp = exp;
        return v;
    endfunction

    function automatic logic is_amo(input amo_op_e a);
        return (a >= AMOSwap) && (a <= AMOMinu);
    endfunction

    task automatic drive1(input logic wr, input amo_op_e amo,
                          input logic [31:0] addr,
                          input logic [63:0] data,
                          input logic [7:0] strb);
        req1.q_valid = 1'b1;
        req1.q.write = wr;
        req1.q.amo   = amo;
        req1.q.addr  = addr;
        req1.q.data  = data;
        req1.q.strb  = strb;
    endtask

    task automatic drive3(input logic wr, input logic [31:0] addr,
                          input logic [63:0] data);
        req3.q_valid = 1'b1;
        req3.q.write = wr;
        req3.q.amo   = AMONone;
        req3.q.addr  = addr;
        req3.q.data  = data;
        req3.q.strb  = 8'hFF;
    endtask

    initial begin
        int idx;
        bit done;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        stall1 = 1'b0;
        stall3 = 1'b0;
        req1   = '0;
        req3   = '0;

        vecs.push_back(mk(1, AMONone, 5, 64'h0, 8'hFF, 0, 64'h0));
        vecs.push_back(mk(1, AMONone, 5, 64'h1122334455667788, 8'hFF,
                          1, 64'h0));
        vecs.push_back(mk(0, AMONone, 5, 64'h0, 8'h00,
                          1, 64'h1122334455667788));
        vecs.push_back(mk(1, AMONone, 5, 64'hAAAAAAAAAAAAAAAA, 8'h0F,
                          1, 64'h1122334455667788));
        vecs.push_back(mk(0, AMONone, 5, 64'h0, 8'h00,
                          1, 64'h11223344AAAAAAAA));
        vecs.push_back(mk(1, AMONone, 3, 64'h12345678FFFFFFFF, 8'hFF,
                          0, 64'h0));
        vecs.push_back(mk(0, AMOAdd, 3, 64'h2, 8'h0F,
                          1, 64'h12345678FFFFFFFF));
        vecs.push_back(mk(0, AMONone, 3, 64'h0, 8'h00,
                          1, 64'h1234567800000001));
        vecs.push_back(mk(1, AMONone, 4, 64'h0000000100000001, 8'hFF,
                          0, 64'h0));
        vecs.push_back(mk(0, AMOMax, 4, 64'h8000000080000000, 8'h0F,
                          1, 64'h0000000100000001));
        vecs.push_back(mk(0, AMONone, 4, 64'h0, 8'h00,
                          1, 64'h0000000100000001));
        vecs.push_back(mk(0, AMOMaxu, 4, 64'h8000000000000000, 8'hF0,
                          1, 64'h0000000100000001));
        vecs.push_back(mk(0, AMONone, 4, 64'h0, 8'h00,
                          1, 64'h8000000000000001));
        vecs.push_back(mk(1, AMOSC, 6, 64'hCAFE, 8'hFF, 1, 64'h0));
        vecs.push_back(mk(0, AMONone, 6, 64'h0, 8'h00, 1, 64'hCAFE));
        vecs.push_back(mk(0, AMONone, 517, 64'h0, 8'h00,
                          1, 64'h11223344AAAAAAAA));
        vecs.push_back(mk(1, AMOSwap, 6, 64'h55, 8'h0F, 1, 64'hCAFE));
        vecs.push_back(mk(0, AMONone, 6, 64'h0, 8'h00, 1, 64'h55));
        vecs.push_back(mk(0, AMOXor, 6, 64'hFF, 8'h0F, 1, 64'h55));
        vecs.push_back(mk(0, AMONone, 6, 64'h0, 8'h00, 1, 64'hAA));
        vecs.push_back(mk(0, AMOMin, 6, 64'hFFFFFFFF, 8'h0F, 1, 64'hAA));
        vecs.push_back(mk(0, AMONone, 6, 64'h0, 8'h00,
                          1, 64'hFFFFFFFF));
        vecs.push_back(mk(0, AMOMinu, 6, 64'h10, 8'h0F,
                          1, 64'hFFFFFFFF));
        vecs.push_back(mk(0, AMONone, 6, 64'h0, 8'h00, 1, 64'h10));
        vecs.push_back(mk(0, AMOOr, 6, 64'h0F, 8'h0F, 1, 64'h10));
        vecs.push_back(mk(0, AMONone, 6, 64'h0, 8'h00, 1, 64'h1F));
        vecs.push_back(mk(0, AMOAnd, 6, 64'h0C, 8'h0F, 1, 64'h1F));
        vecs.push_back(mk(0, AMONone, 6, 64'h0, 8'h00, 1, 64'h0C));

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready1", 64'(rsp1.q_ready), 64'h1);
        chk("rst_data1", rsp1.p.data, 64'h0);
        chk("rst_data3", rsp3.p.data, 64'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive1(vecs[i].wr, vecs[i].amo, vecs[i].addr,
                   vecs[i].data, vecs[i].strb);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(rsp1.q_ready), 64'h1);
            @(negedge clk);
            req1.q_valid = 1'b0;
            #1;
            if (vecs[i].chk)
                chk($sformatf("v%0d_data", i), rsp1.p.data, vecs[i].exp);
            if (is_amo(vecs[i].amo)) begin
                chk($sformatf("v%0d_busy", i), 64'(rsp1.q_ready), 64'h0);
                @(negedge clk);
                #1;
                chk($sformatf("v%0d_free", i), 64'(rsp1.q_ready), 64'h1);
            end
        end

        @(negedge clk);
        stall1 = 1'b1;
        #1;
        chk("stall_ready", 64'(rsp1.q_ready), 64'h0);
        stall1 = 1'b0;
        #1;
        chk("unstall_ready", 64'(rsp1.q_ready), 64'h1);

        @(negedge clk);
        drive1(0, AMONone, 5, 64'h0, 8'h00);
        @(negedge clk);
        drive1(0, AMONone, 4, 64'h0, 8'h00);
        #1;
        chk("b2b_first", rsp1.p.data, 64'h11223344AAAAAAAA);
        @(negedge clk);
        req1.q_valid = 1'b0;
        #1;
        chk("b2b_second", rsp1.p.data, 64'h8000000000000001);

        @(negedge clk);
        drive1(1, AMONone, 2, 64'h7, 8'hFF);
        @(negedge clk);
        drive1(1, AMOSwap, 2, 64'hDEAD, 8'h0F);
        @(negedge clk);
        req1.q_valid = 1'b0;
        #1;
        chk("rstamo_busy", 64'(rsp1.q_ready), 64'h0);
        #1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstamo_ready", 64'(rsp1.q_ready), 64'h1);
        chk("rstamo_data", rsp1.p.data, 64'h0);
        @(negedge clk);
        drive1(0, AMONone, 2, 64'h0, 8'h00);
        @(negedge clk);
        req1.q_valid = 1'b0;
        #1;
        chk("rstamo_mem", rsp1.p.data, 64'h7);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive3(1, 32'(i), 64'(i * 3));
        end
        @(negedge clk);
        req3.q_valid = 1'b0;

        idx  = 0;
        done = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (pend.size() > 0 && pend[0].due == c) begin
                chk($sformatf("l3_data_c%0d", c), rsp3.p.data,
                    pend[0].val);
                void'(pend.pop_front());
            end
            stall3 = ((c / 4) % 2) == 1;
            if (idx < 8)
                drive3(0, 32'(idx), 64'h0);
            else
                req3.q_valid = 1'b0;
            #1;
            chk($sformatf("l3_ready_c%0d", c), 64'(rsp3.q_ready),
                64'(!stall3));
            if (idx < 8 && !stall3) begin
                pend.push_back('{c + 3, 64'(idx * 3)});
                idx++;
            end
            done = (idx == 8) && (pend.size() == 0);
        end
        req3.q_valid = 1'b0;
        stall3 = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL l3_timeout actual=%0d required=8", idx);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
